tl_ul_sram_responder: RTL

TileLink-UL responder (manager/slave end) that terminates the A/D channel pair monitored by the TL protocol monitors in the subsystem. Accepts Get/PutFullData/PutPartialData on channel A, reads or writes a word-addressed on-chip SRAM array, and returns AccessAckData/AccessAck on channel D through a small response queue. Used as a scratchpad or test target behind the TL crossbar.

---
 rtl/tl_ul_sram_responder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder: Get/PutFullData/PutPartialData into a word-addressed SRAM, in-order D queue.
// Define TL_RESPONDER_ERR_COUNT_EN to enable the saturating denied-response counter on err_count.
module tl_ul_sram_responder #(
   parameter int unsigned       ADDR_W    = 30,
   parameter int unsigned       SOURCE_W  = 7,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       DEPTH     = 256,
   parameter int unsigned       RESP_Q    = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [2:0]          a_opcode,
   input  logic [2:0]          a_param,
   input  logic [1:0]          a_size,
   input  logic [SOURCE_W-1:0] a_source,
   input  logic [ADDR_W-1:0]   a_address,
   input  logic [3:0]          a_mask,
   input  logic [31:0]         a_data,
   input  logic                a_corrupt,
   output logic                d_valid,
   input  logic                d_ready,
   output logic [2:0]          d_opcode,
   output logic [1:0]          d_param,
   output logic [1:0]          d_size,
   output logic [SOURCE_W-1:0] d_source,
   output logic                d_denied,
   output logic [31:0]         d_data,
   output logic                d_corrupt,
   output logic [15:0]         err_count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = $clog2(RESP_Q);
   localparam int unsigned CNT_W = $clog2(RESP_Q + 1);

   localparam logic [2:0] OP_PUT_FULL = 3'd0;
   localparam logic [2:0] OP_PUT_PART = 3'd1;
   localparam logic [2:0] OP_GET      = 3'd4;

   typedef struct packed {
      logic                ack_data;
      logic [1:0]          size;
      logic [SOURCE_W-1:0] source;
      logic                denied;
      logic [31:0]         data;
      logic                corrupt;
   } resp_t;

   // ---------------- A-channel decode ----------------
   logic              a_ready_q, a_ready_d;
   logic              a_fire;
   logic [ADDR_W:0]   a_off_ext;
   logic [ADDR_W-1:0] a_word;
   logic [IDX_W-1:0]  a_idx;
   logic [3:0]        lanes;
   logic              op_bad, param_bad, size_bad, align_bad, range_bad, mask_bad;
   logic              a_denied, a_is_get, a_is_put;
   logic              wr_en, rd_en;

   assign a_fire    = a_valid & a_ready_q;
   assign a_ready   = a_ready_q;
   // The extra MSB of the subtraction is the borrow: set when address < BASE_ADDR.
   assign a_off_ext = {1'b0, a_address} - {1'b0, BASE_ADDR};
   assign a_word    = a_off_ext[ADDR_W-1:0] >> 2;
   assign a_idx     = a_word[IDX_W-1:0];
   assign a_is_get  = (a_opcode == OP_GET);
   assign a_is_put  = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);

   always_comb begin
      lanes = 4'h0;
      case (a_size)
         2'd0:    lanes = 4'h1 << a_address[1:0];
         2'd1:    lanes = a_address[1] ? 4'hC : 4'h3;
         2'd2:    lanes = 4'hF;
         default: lanes = 4'h0;
      endcase
   end

   always_comb begin
      op_bad    = !(a_is_get || a_is_put);
      param_bad = (a_param != 3'd0);
      size_bad  = (a_size == 2'd3);
      align_bad = ((a_size == 2'd1) && a_address[0]) ||
                  ((a_size == 2'd2) && (a_address[1:0] != 2'b00));
      range_bad = a_off_ext[ADDR_W] || (a_word >= ADDR_W'(DEPTH));
      mask_bad  = ((a_opcode == OP_PUT_FULL) && (a_mask != lanes)) ||
                  ((a_opcode == OP_PUT_PART) && ((a_mask & ~lanes) != 4'h0));
      a_denied  = op_bad | param_bad | size_bad | align_bad | range_bad | mask_bad;
   end

   assign wr_en = a_fire & a_is_put & ~a_denied & ~a_corrupt;
   assign rd_en = a_fire & a_is_get & ~a_denied;

   // ---------------- SRAM (not reset) ----------------
   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (a_mask[b]) mem[a_idx][8*b +: 8] <= a_data[8*b +: 8];
         end
      end
      if (rd_en) rdata_q <= mem[a_idx];
   end

   // ---------------- Stage 1 and response queue ----------------
   logic                s1_valid_q, s1_get_q, s1_denied_q;
   logic [1:0]          s1_size_q;
   logic [SOURCE_W-1:0] s1_source_q;
   resp_t               s1_resp;

   resp_t               q_mem_q [RESP_Q];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    q_count_q, q_count_d;
   logic [CNT_W:0]      occ_d;
   logic                enq, deq;
   resp_t               head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_Q - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      s1_resp          = '0;
      s1_resp.ack_data = s1_get_q;
      s1_resp.size     = s1_size_q;
      s1_resp.source   = s1_source_q;
      s1_resp.denied   = s1_denied_q;
      s1_resp.data     = (s1_get_q && !s1_denied_q) ? rdata_q : 32'h0;
      s1_resp.corrupt  = s1_get_q && s1_denied_q;
   end

   assign enq = s1_valid_q;
   assign deq = d_valid & d_ready;

   // Stage 1 is counted as occupied so it can always drain into the queue unconditionally.
   always_comb begin
      q_count_d = q_count_q + CNT_W'(enq) - CNT_W'(deq);
      occ_d     = {1'b0, q_count_d} + (CNT_W+1)'(a_fire);
      a_ready_d = (occ_d < (CNT_W+1)'(RESP_Q));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_ready_q   <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_get_q    <= 1'b0;
         s1_denied_q <= 1'b0;
         s1_size_q   <= '0;
         s1_source_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         q_count_q   <= '0;
         for (int unsigned i = 0; i < RESP_Q; i++) q_mem_q[i] <= '0;
      end else begin
         a_ready_q  <= a_ready_d;
         s1_valid_q <= a_fire;
         if (a_fire) begin
            s1_get_q    <= a_is_get;
            s1_denied_q <= a_denied;
            s1_size_q   <= a_size;
            s1_source_q <= a_source;
         end
         if (enq) begin
            q_mem_q[wr_ptr_q] <= s1_resp;
            wr_ptr_q          <= ptr_inc(wr_ptr_q);
         end
         if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
         q_count_q <= q_count_d;
      end
   end

   // ---------------- D channel ----------------
   assign head      = q_mem_q[rd_ptr_q];
   assign d_valid   = (q_count_q != '0);
   assign d_opcode  = d_valid ? {2'b00, head.ack_data} : 3'd0;
   assign d_param   = 2'd0;
   assign d_size    = d_valid ? head.size : 2'd0;
   assign d_source  = d_valid ? head.source : '0;
   assign d_denied  = d_valid & head.denied;
   assign d_data    = d_valid ? head.data : 32'h0;
   assign d_corrupt = d_valid & head.corrupt;

`ifdef TL_RESPONDER_ERR_COUNT_EN
   logic [15:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (deq && d_denied && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) err_q <= '0;
      else       err_q <= err_d;
   end

   assign err_count = err_q;
`else
   assign err_count = 16'h0;
`endif

endmodule
